// File: rtl/sample_capture_if.sv
// -----------------------------------------------------------------------------
// sample_capture_if
//   Groups the streaming sample input and the output FIFO write port of the
//   sample capture block.
//
//   Handshake semantics: sample_valid qualifies sample_in for exactly one
//   cycle and has no back-pressure, so the capture block accepts every valid
//   sample. On the FIFO side, fifo_wr_en is a one-cycle strobe that carries
//   fifo_din. A write is only issued for a sample that arrived while fifo_full
//   was low. A sample that arrives while fifo_full is high is dropped rather
//   than stalled.
//
//   Modports:
//     master : the capture block. It consumes samples and FIFO status and
//              drives the FIFO write port.
//     slave  : the surroundings. They drive samples and FIFO status and see
//              the writes.
// -----------------------------------------------------------------------------
interface sample_capture_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             fifo_full;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_wr_en;

  modport master (
    input  sample_in,
    input  sample_valid,
    input  fifo_full,
    output fifo_din,
    output fifo_wr_en
  );

  modport slave (
    output sample_in,
    output sample_valid,
    output fifo_full,
    input  fifo_din,
    input  fifo_wr_en
  );
endinterface

// File: rtl/sample_capture.sv
// -----------------------------------------------------------------------------
// sample_capture
//   Captures a host-programmed number of signed samples from the summed
//   sinusoid stream into the output FIFO. It supports an immediate trigger or
//   a rising crossing of a signed level, and integer decimation. Busy, done
//   and overflow status are reported for host wire-outs.
//
// Ports
//   clk, reset_n  : single rising-edge clock; asynchronous active-low reset
//   bus (master)  : sample_in/sample_valid in; fifo_full in;
//                   fifo_din/fifo_wr_en out
//   start         : capture request level; its rising edge arms a capture
//   abort         : synchronous return to IDLE; takes priority over start
//   capture_len   : number of samples to take (latched on the start edge)
//   decimate      : keep 1 of every decimate+1 valid samples (latched)
//   trig_mode     : 0 = immediate, 1 = rising crossing of trig_level
//   trig_level    : signed trigger threshold (latched)
//   busy          : high while armed or capturing
//   done          : high in DONE until the next start edge or an abort
//   overflow      : sticky; a candidate sample was dropped on fifo_full
//   stored_cnt    : samples actually written in the current/last capture
//   state_dbg     : current FSM state (0 idle, 1 arm, 2 capture, 3 done)
// -----------------------------------------------------------------------------
module sample_capture #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16,
  parameter int DEC_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  sample_capture_if.master bus,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] capture_len,
  input  logic [DEC_W-1:0] decimate,
  input  logic             trig_mode,
  input  logic [WIDTH-1:0] trig_level,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LEN_W-1:0] stored_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DEC_W-1:0] DEC_ONE = {{(DEC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                    start_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        taken_q;
  logic [DEC_W-1:0]        dec_q;
  logic [DEC_W-1:0]        dec_cnt_q;
  logic signed [WIDTH-1:0] level_q;
  logic signed [WIDTH-1:0] prev_q;

  logic start_edge;
  logic load;
  logic crossing;
  logic candidate;
  logic last_cand;
  logic dec_step;

  // Shared decode used by both the FSM and the datapath.
  always_comb begin
    start_edge = start & ~start_q;
    load       = start_edge && !abort && (state_q == S_IDLE || state_q == S_DONE);
    crossing   = bus.sample_valid && (prev_q < level_q) &&
                 ($signed(bus.sample_in) >= level_q);
    // The sample that fires the trigger is also the first candidate. That is
    // why ARM can produce a candidate in the same cycle it leaves.
    candidate  = !abort &&
                 ((state_q == S_ARM && trig_mode && crossing) ||
                  (state_q == S_CAPTURE && bus.sample_valid && dec_cnt_q == '0));
    last_cand  = candidate && ((taken_q + LEN_ONE) == len_q);
    // Only valid samples seen during capture (including the trigger) advance
    // the decimation phase.
    dec_step   = !abort && (candidate || (state_q == S_CAPTURE && bus.sample_valid));
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge) state_d = (capture_len == '0) ? S_DONE : S_ARM;
        end
        S_ARM: begin
          if (last_cand)                   state_d = S_DONE;
          else if (!trig_mode || candidate) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (last_cand) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = (state_q == S_ARM) || (state_q == S_CAPTURE);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Datapath: edge detect, latched controls, counters and FIFO write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q        <= 1'b0;
      len_q          <= '0;
      taken_q        <= '0;
      dec_q          <= '0;
      dec_cnt_q      <= '0;
      level_q        <= '0;
      prev_q         <= '0;
      overflow       <= 1'b0;
      stored_cnt     <= '0;
      bus.fifo_din   <= '0;
      bus.fifo_wr_en <= 1'b0;
    end else begin
      start_q        <= start;
      bus.fifo_wr_en <= 1'b0;
      // The previous sample is tracked in every state so that a trigger can
      // fire on the first sample seen after arming.
      if (bus.sample_valid) prev_q <= $signed(bus.sample_in);

      if (load) begin
        len_q      <= capture_len;
        dec_q      <= decimate;
        level_q    <= $signed(trig_level);
        taken_q    <= '0;
        dec_cnt_q  <= '0;
        overflow   <= 1'b0;
        stored_cnt <= '0;
      end else begin
        if (dec_step) begin
          dec_cnt_q <= (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_ONE;
        end
        if (candidate) begin
          // A dropped sample still counts as taken, so the captured record
          // keeps its spacing in time.
          taken_q <= taken_q + LEN_ONE;
          if (bus.fifo_full) begin
            overflow <= 1'b1;
          end else begin
            bus.fifo_din   <= bus.sample_in;
            bus.fifo_wr_en <= 1'b1;
            stored_cnt     <= stored_cnt + LEN_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_sample_capture
//   Directed and randomized scenarios for sample_capture. Each scenario is a
//   per-cycle table of inputs. A reference model expresses the capture rules
//   directly: it finds the trigger sample, takes every (decimate+1)-th valid
//   sample after it, and stops at len. From that it predicts the FIFO writes
//   and the status outputs for every cycle.
// -----------------------------------------------------------------------------
module tb_sample_capture;
  localparam int WIDTH = 16;
  localparam int LEN_W = 16;
  localparam int DEC_W = 8;
  localparam int MAXN  = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sample_capture_if #(.WIDTH(WIDTH)) bus ();

  logic             start;
  logic             abort;
  logic [LEN_W-1:0] capture_len;
  logic [DEC_W-1:0] decimate;
  logic             trig_mode;
  logic [WIDTH-1:0] trig_level;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [LEN_W-1:0] stored_cnt;
  logic [1:0]       state_dbg;

  sample_capture #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DEC_W(DEC_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.master),
    .start       (start),
    .abort       (abort),
    .capture_len (capture_len),
    .decimate    (decimate),
    .trig_mode   (trig_mode),
    .trig_level  (trig_level),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .stored_cnt  (stored_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];

  logic                    v_a  [MAXN];
  logic [WIDTH-1:0]        s_a  [MAXN];
  logic                    f_a  [MAXN];
  logic                    st_a [MAXN];
  int                      abort_at;
  logic signed [WIDTH-1:0] last_valid;
  logic [LEN_W-1:0]        end_stored;
  logic                    end_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stim(input int n);
    for (int c = 0; c < MAXN; c++) begin
      v_a[c]  = 1'b0;
      s_a[c]  = '0;
      f_a[c]  = 1'b0;
      st_a[c] = (c < n);
    end
    abort_at = -1;
  endtask

  // Runs n cycles from the stimulus tables. It must be entered just after a
  // falling edge, with start low in the previous cycle.
  task automatic run_scenario(input string name, input int n, input int len, input int dec,
                              input logic mode, input logic signed [WIDTH-1:0] level);
    logic signed [WIDTH-1:0] prev;
    logic signed [WIDTH-1:0] sv;
    logic                    exp_b [MAXN];
    logic                    exp_d [MAXN];
    int                      exp_st[MAXN];
    logic                    exp_ov[MAXN];
    int   first;
    int   taken;
    int   k;
    int   stored;
    int   end_cyc;
    int   stop;
    logic trig;
    logic ovf;
    logic exp_w;

    // Reference model: rules of the capture, evaluated over the whole table.
    prev    = last_valid;
    first   = (mode == 1'b0) ? 2 : 1;
    stop    = (abort_at >= 0) ? abort_at : n;
    taken   = 0;
    k       = 0;
    stored  = 0;
    end_cyc = -1;
    trig    = 1'b0;
    ovf     = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int c = 0; c < n; c++) begin
      sv = s_a[c];
      if (len != 0 && c >= first && c < stop && taken < len && v_a[c]) begin
        if (!trig && (mode == 1'b0 || (prev < level && sv >= level))) trig = 1'b1;
        if (trig) begin
          if (k % (dec + 1) == 0) begin
            taken++;
            if (f_a[c]) ovf = 1'b1;
            else begin
              stored++;
              exp_q.push_back(s_a[c]);
              exp_cyc_q.push_back(c);
            end
            if (taken == len) end_cyc = c;
          end
          k++;
        end
      end
      if (v_a[c]) prev = sv;
      exp_st[c] = stored;
      exp_ov[c] = ovf;
      if (abort_at >= 0 && c >= abort_at) begin exp_b[c] = 1'b0; exp_d[c] = 1'b0; end
      else if (len == 0)                  begin exp_b[c] = 1'b0; exp_d[c] = 1'b1; end
      else if (end_cyc >= 0)              begin exp_b[c] = 1'b0; exp_d[c] = 1'b1; end
      else                                begin exp_b[c] = 1'b1; exp_d[c] = 1'b0; end
    end
    end_stored = LEN_W'(stored);
    end_ovf    = ovf;

    // Drive and compare cycle by cycle.
    capture_len = LEN_W'(len);
    decimate    = DEC_W'(dec);
    trig_mode   = mode;
    trig_level  = level;
    for (int c = 0; c < n; c++) begin
      start            = st_a[c];
      abort            = (c == abort_at);
      bus.sample_valid = v_a[c];
      bus.sample_in    = s_a[c];
      bus.fifo_full    = f_a[c];
      if (v_a[c]) last_valid = s_a[c];
      @(posedge clk);
      @(negedge clk);
      exp_w = (exp_cyc_q.size() > 0 && exp_cyc_q[0] == c);
      check({name, "_wr_en"}, 32'(bus.fifo_wr_en), 32'(exp_w));
      if (exp_w) begin
        check({name, "_din"}, 32'(bus.fifo_din), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      check({name, "_busy"},     32'(busy),       32'(exp_b[c]));
      check({name, "_done"},     32'(done),       32'(exp_d[c]));
      check({name, "_stored"},   32'(stored_cnt), 32'(exp_st[c]));
      check({name, "_overflow"}, 32'(overflow),   32'(exp_ov[c]));
    end
    bus.sample_valid = 1'b0;
    bus.fifo_full    = 1'b0;
  endtask

  // An abort returns to IDLE and must keep stored_cnt/overflow for readback.
  task automatic finish_with_abort(input string name);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check({name, "_abort_busy"},   32'(busy),           32'(1'b0));
    check({name, "_abort_done"},   32'(done),           32'(1'b0));
    check({name, "_abort_wr"},     32'(bus.fifo_wr_en), 32'(1'b0));
    check({name, "_abort_stored"}, 32'(stored_cnt),     32'(end_stored));
    check({name, "_abort_ovf"},    32'(overflow),       32'(end_ovf));
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int len_r;
    int dec_r;
    logic mode_r;
    logic signed [WIDTH-1:0] lvl_r;

    reset_n          = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    capture_len      = '0;
    decimate         = '0;
    trig_mode        = 1'b0;
    trig_level       = '0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.fifo_full    = 1'b0;
    last_valid       = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   32'(busy),           32'(1'b0));
    check("reset_done",   32'(done),           32'(1'b0));
    check("reset_ovf",    32'(overflow),       32'(1'b0));
    check("reset_stored", 32'(stored_cnt),     32'(0));
    check("reset_wr",     32'(bus.fifo_wr_en), 32'(1'b0));
    check("reset_din",    32'(bus.fifo_din),   32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Immediate trigger, no decimation: writes 1,2,3,4.
    clear_stim(12);
    for (int c = 0; c < 12; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c - 1); end
    run_scenario("imm", 12, 4, 0, 1'b0, 16'sd0);
    finish_with_abort("imm");

    // Decimate by 3: writes 10,13,16.
    clear_stim(14);
    for (int c = 0; c < 14; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c + 8); end
    run_scenario("dec", 14, 3, 2, 1'b0, 16'sd0);
    finish_with_abort("dec");

    // Rising crossing of level 0: writes 0,3,-2.
    clear_stim(10);
    v_a[1] = 1'b1; s_a[1] = -16'sd5;
    v_a[2] = 1'b1; s_a[2] = -16'sd1;
    v_a[3] = 1'b1; s_a[3] =  16'sd0;
    v_a[4] = 1'b1; s_a[4] =  16'sd3;
    v_a[5] = 1'b1; s_a[5] = -16'sd2;
    v_a[6] = 1'b1; s_a[6] =  16'sd4;
    run_scenario("trig", 10, 3, 0, 1'b1, 16'sd0);
    finish_with_abort("trig");

    // FIFO full on the second candidate: writes 1,3,4 and overflow.
    clear_stim(12);
    for (int c = 0; c < 12; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c - 1); end
    f_a[3] = 1'b1;
    run_scenario("full", 12, 4, 0, 1'b0, 16'sd0);
    finish_with_abort("full");

    // Zero length goes straight to done.
    clear_stim(4);
    for (int c = 0; c < 4; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c + 50); end
    run_scenario("len0", 4, 0, 0, 1'b0, 16'sd0);
    finish_with_abort("len0");

    // A new start edge during capture is ignored.
    clear_stim(16);
    for (int c = 0; c < 16; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c * 3); end
    st_a[3] = 1'b0;
    run_scenario("restart", 16, 5, 1, 1'b0, 16'sd0);
    finish_with_abort("restart");

    // Abort after two writes.
    clear_stim(8);
    for (int c = 0; c < 8; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c + 20); end
    abort_at = 4;
    run_scenario("abort", 8, 6, 0, 1'b0, 16'sd0);
    finish_with_abort("abort");

    // Randomized scenarios.
    for (int t = 0; t < 8; t++) begin
      clear_stim(40);
      len_r  = int'($urandom_range(6, 1));
      dec_r  = int'($urandom_range(3, 0));
      mode_r = 1'($urandom_range(1, 0));
      r      = int'($urandom_range(20, 0)) - 10;
      lvl_r  = WIDTH'(r);
      for (int c = 0; c < 40; c++) begin
        v_a[c] = ($urandom_range(3, 0) != 0);
        r      = int'($urandom_range(40, 0)) - 20;
        s_a[c] = WIDTH'(r);
        f_a[c] = ($urandom_range(4, 0) == 0);
      end
      run_scenario($sformatf("rand%0d", t), 40, len_r, dec_r, mode_r, lvl_r);
      finish_with_abort($sformatf("rand%0d", t));
    end

    // Asynchronous reset while a write strobe is high.
    clear_stim(4);
    for (int c = 0; c < 4; c++) begin v_a[c] = 1'b1; s_a[c] = WIDTH'(c + 100); end
    run_scenario("rstcap", 4, 8, 0, 1'b0, 16'sd0);
    #1;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("rstcap_busy",   32'(busy),           32'(1'b0));
    check("rstcap_done",   32'(done),           32'(1'b0));
    check("rstcap_ovf",    32'(overflow),       32'(1'b0));
    check("rstcap_stored", 32'(stored_cnt),     32'(0));
    check("rstcap_wr",     32'(bus.fifo_wr_en), 32'(1'b0));
    check("rstcap_din",    32'(bus.fifo_din),   32'(0));
    @(negedge clk);
    reset_n    = 1'b1;
    last_valid = '0;
    @(negedge clk);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
